// File: rtl/hc4511_scan_pkg.sv
// rtl/hc4511_scan_pkg.sv - shared state encoding and default timing constants for the 4511 scan driver
package hc4511_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int DEF_DIGITS    = 4;
  localparam int DEF_DIV       = 1000;
  localparam int DEF_BLANK_CYC = 16;

endpackage

// File: rtl/hc4511_scan_timer.sv
// rtl/hc4511_scan_timer.sv - per-slot cycle counter with end-of-blank and end-of-slot strobes
module hc4511_scan_timer #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign blank_done = (cnt == CW'(BLANK_CYC - 1));
  assign slot_done  = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hc4511_scan_ctrl.sv
// rtl/hc4511_scan_ctrl.sv - multiplexes packed BCD digits onto one 4511 decoder with blank guard,
// frame-synchronous double buffering and optional leading-zero suppression
module hc4511_scan_ctrl
  import hc4511_scan_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int DIV       = DEF_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic                  Load,
  input  logic                  Lz_En,
  input  logic                  Lamp_Test,
  output logic [3:0]            A,
  output logic                  LT_N,
  output logic                  BI_N,
  output logic                  LE,
  output logic [DIGITS-1:0]     Dig_N,
  output logic                  Frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;

  scan_state_t          state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        shadow_q, shadow_d;
  logic [DW-1:0]        disp_q, disp_d;
  logic                 pending_q, pending_d;
  logic                 boundary;
  logic                 blank_done, slot_done;
  logic [DIGITS-1:0]    zero_mask;
  logic                 run_zero;

  logic [3:0]           a_d;
  logic                 lt_n_d, bi_n_d, le_d, frame_d;
  logic [DIGITS-1:0]    dig_n_d;

  hc4511_scan_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (blank_done) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (slot_done) begin
          state_d = ST_BLANK;
          if (idx_q == IW'(DIGITS - 1)) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // A load coinciding with the frame boundary bypasses the shadow so it shows this frame.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (Load) shadow_d = Data;
    if (boundary) begin
      pending_d = 1'b0;
      if (Load) begin
        disp_d = Data;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (Load) begin
      pending_d = 1'b1;
    end
  end

  // zero_mask[i] = every displayed digit from i up to the MSD is zero.
  always_comb begin
    zero_mask = '0;
    run_zero  = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      run_zero     = run_zero & (disp_d[4*j +: 4] == 4'd0);
      zero_mask[j] = run_zero;
    end
  end

  always_comb begin
    a_d     = disp_d[{idx_d, 2'b00} +: 4];
    lt_n_d  = ~Lamp_Test;
    dig_n_d = '1;
    le_d    = 1'b1;
    bi_n_d  = 1'b0;
    frame_d = boundary;
    if (state_d == ST_SHOW) begin
      dig_n_d[idx_d] = 1'b0;
      le_d           = 1'b0;
      bi_n_d         = ~(Lz_En & (idx_d != '0) & zero_mask[idx_d]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      A         <= 4'd0;
      LT_N      <= 1'b1;
      BI_N      <= 1'b0;
      LE        <= 1'b1;
      Dig_N     <= '1;
      Frame     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      A         <= a_d;
      LT_N      <= lt_n_d;
      BI_N      <= bi_n_d;
      LE        <= le_d;
      Dig_N     <= dig_n_d;
      Frame     <= frame_d;
    end
  end

endmodule

// File: tb/tb_hc4511_scan_ctrl.sv
// tb/tb_hc4511_scan_ctrl.sv - self-checking bench for hc4511_scan_ctrl against a cycle-count reference model
module tb_hc4511_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int DIV       = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Data = 16'h0;
  logic        Load = 1'b0;
  logic        Lz_En = 1'b0;
  logic        Lamp_Test = 1'b0;
  logic [3:0]  A;
  logic        LT_N, BI_N, LE;
  logic [3:0]  Dig_N;
  logic        Frame;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hc4511_scan_ctrl #(
    .DIGITS    (DIGITS),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Data      (Data),
    .Load      (Load),
    .Lz_En     (Lz_En),
    .Lamp_Test (Lamp_Test),
    .A         (A),
    .LT_N      (LT_N),
    .BI_N      (BI_N),
    .LE        (LE),
    .Dig_N     (Dig_N),
    .Frame     (Frame)
  );

  // Reference model: cyc is the index of the current cycle since reset released;
  // slot position, digit index and frame boundaries all follow from plain arithmetic on it.
  int          cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_pend = 1'b0;
  logic        m_lt = 1'b1;
  logic        m_lz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_lt = 1'b1; m_lz = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (cyc % FRAME == 0) begin
        if (Load) m_disp = Data;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (Load) begin
        m_shadow = Data;
        m_pend   = 1'b1;
      end
      m_lt = ~Lamp_Test;
      m_lz = Lz_En;
    end
  end

  function automatic logic [11:0] model_out();
    int          slot;
    logic        show, sup;
    logic [15:0] sh;
    logic [3:0]  dig;
    slot = (cyc / DIV) % DIGITS;
    show = (cyc % DIV) >= BLANK_CYC;
    sh   = m_disp >> (4 * slot);
    sup  = m_lz && (slot != 0) && (sh == 16'h0);
    dig  = show ? ~(4'b0001 << slot) : 4'hF;
    return {sh[3:0], m_lt, show && !sup, !show, dig, (cyc % FRAME == 0) && (cyc > 0)};
  endfunction

  wire [11:0] obs = {A, LT_N, BI_N, LE, Dig_N, Frame};

  task automatic test_reset();
    rst = 1'b1; Load = 1'b0; Lamp_Test = 1'b1; Data = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++; if (Dig_N !== 4'hF) begin errors++; $display("FAIL reset_dig_n got=%b want=1111", Dig_N); end
    checks++; if (BI_N !== 1'b0) begin errors++; $display("FAIL reset_bi_n got=%b want=0", BI_N); end
    checks++; if (LE !== 1'b1) begin errors++; $display("FAIL reset_le got=%b want=1", LE); end
    checks++; if (A !== 4'd0) begin errors++; $display("FAIL reset_a got=%h want=0", A); end
    checks++; if (LT_N !== 1'b1) begin errors++; $display("FAIL reset_lt_n got=%b want=1", LT_N); end
    checks++; if (Frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b want=0", Frame); end
    Lamp_Test = 1'b0; Data = 16'h0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    Data = 16'h1234; Load = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      Load = 1'b0;
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL basic_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc == 0 + FRAME) begin
        checks++; if (Frame !== 1'b1) begin errors++; $display("FAIL basic_frame got=%b want=1", Frame); end
      end
      if (cyc == FRAME + BLANK_CYC) begin
        checks++; if ({A, Dig_N, BI_N} !== {4'd4, 4'b1110, 1'b1}) begin errors++; $display("FAIL basic_idx0 got=%h/%b/%b want=4/1110/1", A, Dig_N, BI_N); end
      end
      if (cyc == FRAME + 3 * DIV + BLANK_CYC) begin
        checks++; if ({A, Dig_N} !== {4'd1, 4'b0111}) begin errors++; $display("FAIL basic_idx3 got=%h/%b want=1/0111", A, Dig_N); end
      end
    end
  endtask

  task automatic test_lz();
    int f0;
    Lz_En = 1'b1; Data = 16'h0070; Load = 1'b1;
    f0 = cyc / FRAME + 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      Load = 1'b0;
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL lz_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc / FRAME == f0 && cyc % DIV == BLANK_CYC) begin
        case ((cyc % FRAME) / DIV)
          3, 2: begin checks++; if (BI_N !== 1'b0) begin errors++; $display("FAIL lz_hi_blank cyc=%0d got=%b want=0", cyc, BI_N); end end
          1: begin checks++; if ({A, BI_N} !== {4'd7, 1'b1}) begin errors++; $display("FAIL lz_d1 got=%h/%b want=7/1", A, BI_N); end end
          default: begin checks++; if ({A, BI_N} !== {4'd0, 1'b1}) begin errors++; $display("FAIL lz_d0 got=%h/%b want=0/1", A, BI_N); end end
        endcase
      end
    end
    Data = 16'h0000; Load = 1'b1;
    f0 = cyc / FRAME + 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      Load = 1'b0;
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL lz0_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc / FRAME == f0 && cyc % DIV == BLANK_CYC + 1) begin
        checks++;
        if (BI_N !== ((cyc % FRAME) < DIV)) begin errors++; $display("FAIL lz_zero cyc=%0d got=%b want=%b", cyc, BI_N, (cyc % FRAME) < DIV); end
      end
    end
    Lz_En = 1'b0;
  endtask

  task automatic test_midframe_load();
    int f0;
    for (int k = 0; k < 2 * FRAME && cyc % FRAME != DIV + 3; k++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL mid_seek cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
    end
    checks++; if (cyc % FRAME != DIV + 3) begin errors++; $display("FAIL mid_timeout cyc=%0d want_pos=%0d", cyc, DIV + 3); end
    Data = 16'h5555; Load = 1'b1;
    f0 = cyc / FRAME;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      Load = 1'b0;
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL mid_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc / FRAME == f0 && (cyc % FRAME == 2 * DIV + 2 || cyc % FRAME == 3 * DIV + 2)) begin
        checks++; if (A !== 4'd0) begin errors++; $display("FAIL mid_old cyc=%0d got=%h want=0", cyc, A); end
      end
      if (cyc / FRAME == f0 + 1 && cyc % FRAME == 0) begin
        checks++; if ({Frame, A} !== {1'b1, 4'd5}) begin errors++; $display("FAIL mid_new got=%b/%h want=1/5", Frame, A); end
      end
    end
  endtask

  task automatic test_boundary_load();
    for (int k = 0; k < 2 * FRAME && cyc % FRAME != FRAME - 1; k++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL bnd_seek cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
    end
    checks++; if (cyc % FRAME != FRAME - 1) begin errors++; $display("FAIL bnd_timeout cyc=%0d", cyc); end
    Data = 16'h9876; Load = 1'b1;
    @(negedge clk);
    Load = 1'b0;
    checks++; if ({Frame, A} !== {1'b1, 4'd6}) begin errors++; $display("FAIL bnd_first got=%b/%h want=1/6", Frame, A); end
    for (int i = 0; i < DIV + BLANK_CYC; i++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL bnd_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc % FRAME == BLANK_CYC) begin
        checks++; if ({A, Dig_N} !== {4'd6, 4'b1110}) begin errors++; $display("FAIL bnd_idx0 got=%h/%b want=6/1110", A, Dig_N); end
      end
    end
    checks++; if (A !== 4'd7) begin errors++; $display("FAIL bnd_idx1 got=%h want=7", A); end
  endtask

  task automatic test_lamp();
    int first, second;
    first = -1; second = -1;
    Lamp_Test = 1'b1;
    @(negedge clk);
    checks++; if (LT_N !== 1'b0) begin errors++; $display("FAIL lamp_lt_n got=%b want=0", LT_N); end
    for (int i = 0; i < 3 * FRAME && second < 0; i++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL lamp_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (Frame === 1'b1) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    checks++; if (second - first != FRAME) begin errors++; $display("FAIL lamp_period got=%0d want=%0d", second - first, FRAME); end
    Lamp_Test = 1'b0;
    @(negedge clk);
    checks++; if (LT_N !== 1'b1) begin errors++; $display("FAIL lamp_off got=%b want=1", LT_N); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      Load      = ($urandom_range(0, 9) == 0);
      Data      = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      Lamp_Test = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 20) == 0) Lz_En = ~Lz_En;
    end
    Load = 1'b0; Lamp_Test = 1'b0;
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 2 * FRAME && cyc % FRAME != 2 * DIV + 4; k++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL rst_seek cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
    end
    checks++; if (Dig_N !== 4'b1011) begin errors++; $display("FAIL rst_pre_dig got=%b want=1011", Dig_N); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({Dig_N, BI_N, LE, A, Frame} !== {4'hF, 1'b0, 1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL rst_mid got=%b/%b/%b/%h/%b want=1111/0/1/0/0", Dig_N, BI_N, LE, A, Frame);
    end
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      checks++; if (obs !== model_out()) begin errors++; $display("FAIL rst_model cyc=%0d got=%h want=%h", cyc, obs, model_out()); end
      if (cyc == BLANK_CYC) begin
        checks++; if (Dig_N !== 4'b1110) begin errors++; $display("FAIL rst_restart got=%b want=1110", Dig_N); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_midframe_load();
    test_boundary_load();
    test_lamp();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
